// File: rtl/sync_r2w_ptr.sv
// sync_r2w_ptr: carries the Gray read pointer of an async FIFO into the write
// clock domain, converts it to binary and derives registered fill level,
// full and almost-full flags. Also flags illegal multi-bit Gray steps, which
// point to a CDC or pointer-generation fault upstream.
module sync_r2w_ptr #(
    parameter int DEPTH     = 8,
    parameter int STAGES    = 2,
    parameter int AFULL_LVL = 6,
    localparam int AW       = $clog2(DEPTH),
    localparam int PW       = AW + 1
) (
    input  logic          w_clk,
    input  logic          rst_n,
    input  logic [PW-1:0] rptr,
    input  logic [PW-1:0] wptr_bin,
    input  logic          err_clr,
    output logic [PW-1:0] wsync_ptr,
    output logic [PW-1:0] rptr_bin_sync,
    output logic          rd_adv,
    output logic [PW-1:0] wlevel,
    output logic          w_full,
    output logic          w_afull,
    output logic          gray_err
);

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Number of set bits; a legal Gray step differs in at most one bit.
    function automatic int popcount(input logic [PW-1:0] v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < PW; i++) begin
            cnt = cnt + int'(v[i]);
        end
        return cnt;
    endfunction

    logic [PW-1:0] r_sync [STAGES];
    logic [PW-1:0] r_prev_g;
    logic          r_gray_err;

    logic [PW-1:0] w_rbin;
    logic [PW-1:0] w_level;
    logic          w_full_nxt;
    logic          w_afull_nxt;
    logic          w_viol;
    logic          w_gray_err_nxt;

    // The synchronized pointer is the last flop of the chain, with no logic after it.
    assign wsync_ptr = r_sync[STAGES-1];

    // Next-state level/flags from one converted pointer so the three outputs always agree.
    always_comb begin
        w_rbin      = gray2bin(wsync_ptr);
        w_level     = wptr_bin - w_rbin;
        w_full_nxt  = (wptr_bin[AW] != w_rbin[AW]) &&
                      (wptr_bin[AW-1:0] == w_rbin[AW-1:0]);
        w_afull_nxt = (w_level >= PW'(AFULL_LVL));
        w_viol      = (popcount(wsync_ptr ^ r_prev_g) > 32'sd1);
        if (w_viol) begin
            w_gray_err_nxt = 1'b1;
        end else if (err_clr) begin
            w_gray_err_nxt = 1'b0;
        end else begin
            w_gray_err_nxt = r_gray_err;
        end
    end

    // Plain flop chain moving the read-domain Gray pointer into w_clk.
    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= {PW{1'b0}};
            end
        end else begin
            r_sync[0] <= rptr;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Registered binary pointer, advance pulse, occupancy, flags and sticky error.
    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_g      <= {PW{1'b0}};
            rptr_bin_sync <= {PW{1'b0}};
            rd_adv        <= 1'b0;
            wlevel        <= {PW{1'b0}};
            w_full        <= 1'b0;
            w_afull       <= 1'b0;
            r_gray_err    <= 1'b0;
        end else begin
            r_prev_g      <= wsync_ptr;
            rptr_bin_sync <= w_rbin;
            rd_adv        <= (wsync_ptr != r_prev_g);
            wlevel        <= w_level;
            w_full        <= w_full_nxt;
            w_afull       <= w_afull_nxt;
            r_gray_err    <= w_gray_err_nxt;
        end
    end

    assign gray_err = r_gray_err;

endmodule
